// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
//   One operation in flight. Multiply is shift-add on magnitudes, divide is
//   restoring division on magnitudes; signs are fixed up on the last iteration.
//   Divide-by-zero and signed overflow skip the iteration phase entirely.
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (ready only when idle)
//   Operation            RV32M funct3 (MUL..REMU)
//   SrcA, SrcB, in_tag   operands and destination tag
//   kill                 flush: drop whatever is in flight or waiting
//   out_valid/out_ready  result handshake
//   Result, out_tag      result and its tag (zero while out_valid is 0)
module mul_div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  input  logic                     kill,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic [TAG_WIDTH-1:0]     out_tag
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST    = CW'(W-1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // context captured at acceptance
  typedef struct packed {
    logic                 is_div;
    logic [1:0]           op;     // funct3[1:0]
    logic                 neg;    // final result must be negated
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  state_t          state, next;
  req_t            req_q;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;   // mul: product     | div: remainder in [W:0]
  logic [2*W-1:0]  opa;   // mul: multiplicand| div: dividend -> quotient in [W-1:0]
  logic [W-1:0]    opb;   // mul: multiplier  | div: divisor
  logic [W-1:0]    res_q;

  logic accept;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~kill;
  assign Result    = out_valid ? res_q     : '0;
  assign out_tag   = out_valid ? req_q.tag : '0;

  // ---- request decode ----
  logic op_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf, bypass;
  logic [W-1:0] a_mag, b_mag, byp_res;

  always_comb begin
    op_div   = Operation[2];
    // MULHU is the only multiply with unsigned rs1; MULHSU/MULHU take rs2 unsigned
    a_sgn    = op_div ? ~Operation[0] : (Operation[1:0] != 2'b11);
    b_sgn    = op_div ? ~Operation[0] : ~Operation[1];
    a_neg    = a_sgn & SrcA[W-1];
    b_neg    = b_sgn & SrcB[W-1];
    a_mag    = a_neg ? (~SrcA + 1'b1) : SrcA;
    b_mag    = b_neg ? (~SrcB + 1'b1) : SrcB;
    div_zero = op_div & (SrcB == '0);
    ovf      = op_div & ~Operation[0] & (SrcA == MIN_NEG) & (SrcB == '1);
    bypass   = div_zero | ovf;
    if (div_zero) byp_res = Operation[1] ? SrcA : '1;
    else          byp_res = Operation[1] ? '0   : SrcA;
  end

  // ---- one iteration step ----
  logic [W:0]     r_sh, diff;
  logic           ge;
  logic [2*W-1:0] acc_n, opa_n, prod_fix;
  logic [W-1:0]   opb_n, q_mag, r_mag, fin_res;

  always_comb begin
    r_sh = {acc[W-1:0], opa[W-1]};
    diff = r_sh - {1'b0, opb};
    ge   = ~diff[W];
    if (req_q.is_div) begin
      acc_n = {{(W-1){1'b0}}, (ge ? diff : r_sh)};
      opa_n = {{W{1'b0}}, opa[W-2:0], ge};
      opb_n = opb;
    end else begin
      acc_n = opb[0] ? (acc + opa) : acc;
      opa_n = {opa[2*W-2:0], 1'b0};
      opb_n = {1'b0, opb[W-1:1]};
    end
    prod_fix = req_q.neg ? (~acc_n + 1'b1) : acc_n;
    q_mag    = opa_n[W-1:0];
    r_mag    = acc_n[W-1:0];
    if (req_q.is_div) begin
      if (req_q.op[1]) fin_res = req_q.neg ? (~r_mag + 1'b1) : r_mag;
      else             fin_res = req_q.neg ? (~q_mag + 1'b1) : q_mag;
    end else begin
      fin_res = (req_q.op == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (accept) next = bypass ? DONE : BUSY;
      BUSY: if (cnt == LAST) next = DONE;
      DONE: if (out_ready) next = IDLE;
      default: next = IDLE;
    endcase
    if (kill) next = IDLE;
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      opa   <= '0;
      opb   <= '0;
      res_q <= '0;
    end else if (state == IDLE && accept) begin
      req_q.is_div <= op_div;
      req_q.op     <= Operation[1:0];
      // remainder follows the dividend; everything else follows a xor b
      req_q.neg    <= (op_div & Operation[1]) ? a_neg : (a_neg ^ b_neg);
      req_q.tag    <= in_tag;
      cnt          <= '0;
      acc          <= '0;
      opa          <= {{W{1'b0}}, a_mag};
      opb          <= b_mag;
      res_q        <= bypass ? byp_res : '0;
    end else if (state == BUSY && !kill) begin
      acc <= acc_n;
      opa <= opa_n;
      opb <= opb_n;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) res_q <= fin_res;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (DATA_WIDTH=32): directed multiply,
// divide, bypass, backpressure, kill/reset abort and a random back-to-back run
// checked against an arithmetic reference model.
module tb_mul_div_unit;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, kill = 0;
  logic        out_valid, out_ready = 1;
  logic [2:0]  Operation = 0;
  logic [31:0] SrcA = 0, SrcB = 0, Result;
  logic [4:0]  in_tag = 0, out_tag;

  mul_div_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3), .TAG_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .in_tag(in_tag),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .out_tag(out_tag));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic [4:0] tag; int lat; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb64, p;
    logic [63:0] pu;
    sa = $signed({{32{a[31]}}, a});
    sb64 = $signed({{32{b[31]}}, b});
    case (op)
      3'd0: begin p = sa * sb64; return p[31:0]; end
      3'd1: begin p = sa * sb64; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: if (b == 0) return '1; else if (a == 32'h80000000 && b == '1) return a;
            else return $signed(a) / $signed(b);
      3'd5: if (b == 0) return '1; else return a / b;
      3'd6: if (b == 0) return a; else if (a == 32'h80000000 && b == '1) return 0;
            else return $signed(a) % $signed(b);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == '1))) return 1;
    return 33;
  endfunction

  // drive one request; acceptance edge is the posedge inside this task
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input int lat);
    exp_t e;
    @(negedge clk);
    Operation = op; SrcA = a; SrcB = b; in_tag = tag; in_valid = 1;
    @(posedge clk);
    e.res = res; e.tag = tag; e.lat = lat;
    sb.push_back(e);
    #1;
    in_valid = 0;
    // scramble inputs so a design that reads them late gets caught
    Operation = 3'($urandom); SrcA = $urandom; SrcB = $urandom; in_tag = 5'($urandom);
  endtask

  // edges from acceptance (acceptance edge = 1) until out_valid is seen
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_cmp++; if (Result !== 32'h0) begin n_err++; $display("FAIL rst_result got %h want 0", Result); end
    n_cmp++; if (out_tag !== 5'h0) begin n_err++; $display("FAIL rst_tag got %h want 0", out_tag); end
    reset = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] rs  [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int lat; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'(3 + i), rs[i], 33);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL mul%0d_latency got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (Result !== e.res) begin n_err++; $display("FAIL mul%0d_result got %h want %h", i, Result, e.res); end
      n_cmp++; if (out_tag !== e.tag) begin n_err++; $display("FAIL mul%0d_tag got %h want %h", i, out_tag, e.tag); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul%0d_hold got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] rs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int lat; exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 5'(10 + i), rs[i], 33);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL div%0d_latency got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (Result !== e.res) begin n_err++; $display("FAIL div%0d_result got %h want %h", i, Result, e.res); end
      n_cmp++; if (out_tag !== e.tag) begin n_err++; $display("FAIL div%0d_tag got %h want %h", i, out_tag, e.tag); end
      @(negedge clk);
    end
  endtask

  task automatic test_bypass();
    logic [2:0]  ops [5] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4};
    logic [31:0] as  [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] rs  [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    int lat; exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], 5'(20 + i), rs[i], 1);
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL byp%0d_latency got %0d want %0d", i, lat, e.lat); end
      n_cmp++; if (Result !== e.res) begin n_err++; $display("FAIL byp%0d_result got %h want %h", i, Result, e.res); end
      n_cmp++; if (out_tag !== e.tag) begin n_err++; $display("FAIL byp%0d_tag got %h want %h", i, out_tag, e.tag); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int lat; exp_t e;
    out_ready = 0;
    issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33);
    wait_out(lat);
    e = sb.pop_front();
    // offer a competing request; it must not be taken while results wait
    Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd3; in_tag = 5'd1; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || Result !== e.res || out_tag !== e.tag || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d got v=%b r=%h t=%h rdy=%b want v=1 r=%h t=%h rdy=0",
                          i, out_valid, Result, out_tag, in_ready, e.res, e.tag);
      end
      @(negedge clk);
    end
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_kill();
    int lat; bit seen;
    exp_t e;
    issue(3'd0, 32'd11, 32'd13, 5'd5, 32'd143, 33);
    repeat (10) @(negedge clk);
    kill = 1;
    @(negedge clk);
    kill = 0;
    e = sb.pop_front();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL kill_idle got rdy=%b v=%b want rdy=1 v=0 (tag %0d dropped)", in_ready, out_valid, e.tag);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL kill_no_result got %b want 0", seen); end
    // kill beats a simultaneous request in IDLE
    in_valid = 1; kill = 1;
    @(negedge clk);
    in_valid = 0; kill = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL kill_blocks_accept got rdy=%b want 1", in_ready); end
    lat = 0;
  endtask

  task automatic test_reset_abort();
    int lat; bit seen; exp_t e;
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd17, 32'h0, 33);
    repeat (20) @(negedge clk);
    reset = 1; kill = 1;   // reset must win over kill as well
    @(negedge clk);
    void'(sb.pop_front());
    n_cmp++; if (out_valid !== 1'b0 || Result !== 32'h0 || out_tag !== 5'h0) begin
      n_err++; $display("FAIL rstab_outputs got v=%b r=%h t=%h want all 0", out_valid, Result, out_tag);
    end
    reset = 0; kill = 0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstab_ready got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstab_no_result got %b want 0", seen); end
    issue(3'd0, 32'd2, 32'd3, 5'd7, 32'd6, 33);
    wait_out(lat);
    e = sb.pop_front();
    n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL rstab_mul_latency got %0d want %0d", lat, e.lat); end
    n_cmp++; if (Result !== e.res || out_tag !== e.tag) begin
      n_err++; $display("FAIL rstab_mul got r=%h t=%h want r=%h t=%h", Result, out_tag, e.res, e.tag);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
    logic [2:0] op; logic [31:0] a, b; int lat; exp_t e;
    for (int i = 0; i < 24; i++) begin
      op = 3'(i % 8);
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      issue(op, a, b, 5'(i), ref_model(op, a, b), exp_lat(op, a, b));
      wait_out(lat);
      e = sb.pop_front();
      n_cmp++; if (lat != e.lat || Result !== e.res || out_tag !== e.tag) begin
        n_err++; $display("FAIL b2b%0d op=%0d a=%h b=%h got r=%h t=%h lat=%0d want r=%h t=%h lat=%0d",
                          i, op, a, b, Result, out_tag, lat, e.res, e.tag, e.lat);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_bypass();
    test_backpressure();
    test_kill();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // safety net in case a handshake never completes
  initial begin
    #500000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand and result width; any even value 8..64 SHALL be supported.
REQ-002 Parameter OPCODE_LENGTH, default 3: operation select width, encoded as RV32M funct3.
REQ-003 Parameter TAG_WIDTH, default 5: destination-register tag carried with each operation.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous active-high reset.
- in_valid, in, 1: request present.
- in_ready, out, 1: unit can accept.
- Operation, in, OPCODE_LENGTH: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA, in, DATA_WIDTH: rs1 / multiplicand / dividend.
- SrcB, in, DATA_WIDTH: rs2 / multiplier / divisor.
- in_tag, in, TAG_WIDTH: destination tag.
- kill, in, 1: pipeline flush.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts.
- Result, out, DATA_WIDTH: result.
- out_tag, out, TAG_WIDTH: tag of the operation accepted with this result.

Function
REQ-006 The FSM SHALL have three states: IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-007 Acceptance SHALL occur on a rising edge where in_valid, in_ready and !kill are all 1; Operation, SrcA, SrcB and in_tag SHALL be registered at that edge.
REQ-008 Normal operations SHALL go IDLE->BUSY; BUSY SHALL last exactly DATA_WIDTH cycles (one iteration each, tracked by a counter); the unit SHALL then enter DONE.
- out_valid SHALL first be 1 exactly DATA_WIDTH+1 edges after acceptance.
REQ-009 Multiply SHALL be iterative shift-add over 2*DATA_WIDTH-bit magnitudes with sign correction at the end.
- MUL SHALL return the low half.
- MULH (signed x signed), MULHSU (signed SrcA x unsigned SrcB) and MULHU (unsigned x unsigned) SHALL return the high half.
REQ-010 Divide SHALL be iterative restoring division on magnitudes.
- The quotient SHALL truncate toward zero.
- The remainder SHALL take the sign of the dividend.
- DIV/REM SHALL be signed; DIVU/REMU SHALL be unsigned.
REQ-011 Divisor zero SHALL bypass BUSY (IDLE->DONE, out_valid 1 edge after acceptance).
- DIV and DIVU SHALL return all-ones.
- REM and REMU SHALL return SrcA.
REQ-012 Signed overflow SHALL bypass BUSY the same way: DIV of most-negative by -1 SHALL return most-negative, and REM SHALL return 0.
REQ-013 In DONE, Result and out_tag SHALL be held stable while out_ready is 0; when out_ready is 1 the unit SHALL return to IDLE on that edge.
- No new request SHALL be accepted on that same edge.
REQ-014 kill=1 SHALL force IDLE on the next edge from any state.
- Any in-flight or undelivered result SHALL be discarded.
- kill SHALL override a simultaneous in_valid or out_ready.
REQ-015 Changes on SrcA, SrcB, Operation or in_tag while BUSY or DONE SHALL NOT affect the result.
REQ-016 Result SHALL be 0 whenever out_valid is 0.

Reset
REQ-017 reset SHALL dominate kill and all other inputs.
REQ-018 On a reset edge:
- the state SHALL become IDLE;
- the counter and working registers SHALL be cleared;
- out_valid SHALL be 0, Result SHALL be 0 and out_tag SHALL be 0;
- in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-019 Reset asserted mid-BUSY or in DONE SHALL abort the operation with no result delivered.

Verification (DATA_WIDTH=32, out_ready=1 unless stated)
REQ-020 MUL 7 x 0xFFFFFFFD, tag 3 -> Result 0xFFFFFFEB and out_tag 3, out_valid exactly 33 edges after acceptance, held one cycle.
REQ-021 The following SHALL each be checked:
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-022 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-023 The bypass cases SHALL each have out_valid 1 edge after acceptance:
- DIVU 5/0 -> 0xFFFFFFFF.
- REM 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
REQ-024 Backpressure: with out_ready held 0 for 10 cycles, Result, out_tag and out_valid SHALL stay stable and in_ready SHALL stay 0; after out_ready rises, in_ready SHALL be 1 on the following cycle.
REQ-025 Abort cases:
- kill asserted at BUSY cycle 10 -> IDLE next edge, no out_valid.
- reset asserted at BUSY cycle 20 -> all outputs 0, in_ready 1 after deassert.
- A following MUL 2 x 3 -> 6 at the nominal latency.
